// File: rtl/cic_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cic_pkg
// Brief    : Shared widths, the truncated-sample type and the CIC width helper.
// Revision : 1.0
// ============================================================================
package cic_pkg;

    localparam int C_IN_W       = 11;
    localparam int C_DECIMATION = 64;
    localparam int C_ORDER      = 3;

    typedef logic signed [C_IN_W-1:0] trunc_sample_t;

    // Each stage grows the word by log2(R) bits, so a full-scale input cannot overflow the output.
    function automatic int out_width(input int in_w, input int r, input int order);
        return in_w + order * $clog2(r);
    endfunction

    localparam int C_OUT_W = out_width(C_IN_W, C_DECIMATION, C_ORDER);

endpackage : cic_pkg
`default_nettype wire

// File: rtl/cic_integrator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cic_integrator
// Brief    : One wrapping, enable-gated, clearable CIC integrator stage.
// Revision : 1.0
// ============================================================================
module cic_integrator #(
    parameter int WIDTH = 29
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    clear,
    input  logic signed [WIDTH-1:0] add_in,
    output logic signed [WIDTH-1:0] acc_out
);

    logic signed [WIDTH-1:0] acc_q;
    logic signed [WIDTH-1:0] acc_d;

    // Modulo-2^WIDTH wrap is intentional; the combs undo it exactly.
    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + add_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_out = acc_q;

endmodule : cic_integrator
`default_nettype wire

// File: rtl/cic_decimator_sd.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cic_decimator_sd
// Brief    : ORDER-stage CIC decimator rebuilding high-resolution samples
//            from the noise-shaped truncated stream.
// Revision : 1.0
// ============================================================================
module cic_decimator_sd
    import cic_pkg::*;
#(
    parameter  int IN_W       = C_IN_W,
    parameter  int DECIMATION = C_DECIMATION,
    parameter  int ORDER      = C_ORDER,
    localparam int OUT_W      = out_width(IN_W, DECIMATION, ORDER)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable_3M,
    input  logic                    clear,
    input  logic signed [IN_W-1:0]  sample_in,
    output logic signed [OUT_W-1:0] sample_out,
    output logic                    out_valid
);

    localparam int              PH_W         = $clog2(DECIMATION);
    localparam logic [PH_W-1:0] C_PHASE_LAST = PH_W'(DECIMATION - 1);

    logic [ORDER-1:0][OUT_W-1:0] integ_in;
    logic [ORDER-1:0][OUT_W-1:0] integ_out;

    logic [PH_W-1:0]             phase_q;
    logic [PH_W-1:0]             phase_d;
    logic [ORDER-1:0][OUT_W-1:0] dly_q;
    logic [ORDER-1:0][OUT_W-1:0] dly_d;
    logic [OUT_W-1:0]            sample_out_q;
    logic [OUT_W-1:0]            sample_out_d;
    logic                        out_valid_q;
    logic                        out_valid_d;

    logic                        dec_event;
    logic [OUT_W-1:0]            comb_run;

    assign integ_in[0] = {{(OUT_W - IN_W){sample_in[IN_W-1]}}, sample_in};

    // Each stage feeds the next with its registered (pre-edge) value.
    generate
        for (genvar k = 0; k < ORDER; k++) begin : g_integ
            if (k > 0) begin : g_chain
                assign integ_in[k] = integ_out[k-1];
            end

            cic_integrator #(
                .WIDTH (OUT_W)
            ) u_integ (
                .clk     (clk),
                .reset   (reset),
                .en      (enable_3M),
                .clear   (clear),
                .add_in  (integ_in[k]),
                .acc_out (integ_out[k])
            );
        end
    endgenerate

    assign dec_event = enable_3M && !clear && (phase_q == C_PHASE_LAST);

    always_comb begin
        phase_d      = phase_q;
        dly_d        = dly_q;
        sample_out_d = sample_out_q;
        out_valid_d  = 1'b0;
        comb_run     = integ_out[ORDER-1];

        if (clear) begin
            phase_d = '0;
            dly_d   = '0;
        end else if (enable_3M) begin
            phase_d = phase_q + 1'b1;
            if (dec_event) begin
                // Comb chain evaluated on the last integrator's pre-edge value.
                for (int k = 0; k < ORDER; k++) begin
                    dly_d[k] = comb_run;
                    comb_run = comb_run - dly_q[k];
                end
                sample_out_d = comb_run;
                out_valid_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q      <= '0;
            dly_q        <= '0;
            sample_out_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            dly_q        <= dly_d;
            sample_out_q <= sample_out_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign sample_out = sample_out_q;
    assign out_valid  = out_valid_q;

endmodule : cic_decimator_sd
`default_nettype wire
